// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   funct3_e : M-extension funct3 encodings (MUL..REMU)
//   state_e  : control FSM states
//   DIV_BY_ZERO_Q, INT_MIN : RISC-V special-case result constants
//   magnitude() : absolute value for signed operands, identity otherwise
package muldiv_pkg;

  typedef enum logic [2:0] {
    F_MUL    = 3'd0,
    F_MULH   = 3'd1,
    F_MULHSU = 3'd2,
    F_MULHU  = 3'd3,
    F_DIV    = 3'd4,
    F_DIVU   = 3'd5,
    F_REM    = 3'd6,
    F_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_divider.sv
// Radix-2 restoring divider core operating on unsigned magnitudes.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : load dividend/divisor and begin 32 iterations
//   flush      : abandon the iteration in progress
//   dividend, divisor : unsigned operands sampled on start
//   done       : high during the final (32nd) iteration cycle
//   quotient, remainder : results, valid the cycle after done
module divider_radix2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [5:0]  cnt_q;
  logic        running_q;
  logic [32:0] partial;
  logic [32:0] diff;

  // The quotient register doubles as the dividend shift register: each step
  // shifts the next dividend bit into the remainder and the new quotient bit in.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dsr_q};
  end

  assign done      = running_q && (cnt_q == 6'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (flush) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= dividend;
      dsr_q     <= divisor;
      cnt_q     <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      // diff[32] is the borrow: set when the partial remainder is below the divisor
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= partial[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      if (done) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   in_valid     : M-extension op present (ignored while busy)
//   in_funct3    : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   in_rs1/in_rs2: operands; in_rd destination passed through
//   in_flush     : squash the operation in flight
//   out_busy     : unit not idle, stalls IF/ID/EX
//   out_valid    : one-cycle completion pulse
//   out_result/out_rd : last completed result and destination
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_flush,
  output logic            out_busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  state_e      state_q, state_d;
  funct3_e     op_q;
  logic [31:0] rs1_q, rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        accept;
  logic        in_is_div, in_signed_div, in_div0, in_ovf, in_special;
  logic [31:0] special_res;
  logic [31:0] dividend_mag, divisor_mag;
  logic        div_start, div_done;
  logic [31:0] div_q, div_r;

  logic        a_neg, b_neg;
  logic [63:0] product;
  logic [31:0] mul_res;
  logic [31:0] q_fixed, r_fixed, fix_res;
  logic        load_out;
  logic [31:0] next_result;
  logic [4:0]  next_rd;

  // Decode of the incoming op, only meaningful when accepted.
  always_comb begin
    accept        = (state_q == ST_IDLE) && in_valid && !in_flush;
    in_is_div     = in_funct3[2];
    in_signed_div = !in_funct3[0];
    in_div0       = (in_rs2 == '0);
    in_ovf        = in_signed_div && (in_rs1 == INT_MIN) && (in_rs2 == '1);
    in_special    = in_div0 || in_ovf;
    if (in_div0)
      special_res = in_funct3[1] ? in_rs1 : DIV_BY_ZERO_Q;
    else
      special_res = in_funct3[1] ? '0 : INT_MIN;
    div_start     = accept && in_is_div && !in_special;
    dividend_mag  = magnitude(in_rs1, in_signed_div);
    divisor_mag   = magnitude(in_rs2, in_signed_div);
  end

  divider_radix2 u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .flush     (in_flush),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Signed product built from one unsigned 32x32 multiply: a negative signed
  // operand contributes -2^32 * (other operand), which lands in the high word.
  always_comb begin
    a_neg   = ((op_q == F_MULH) || (op_q == F_MULHSU)) && rs1_q[31];
    b_neg   = (op_q == F_MULH) && rs2_q[31];
    product = ({32'b0, rs1_q} * {32'b0, rs2_q})
            - (a_neg ? {rs2_q, 32'b0} : 64'b0)
            - (b_neg ? {rs1_q, 32'b0} : 64'b0);
    mul_res = (op_q == F_MUL) ? product[31:0] : product[63:32];
  end

  always_comb begin
    q_fixed = ((op_q == F_DIV) && (rs1_q[31] ^ rs2_q[31])) ? (~div_q + 32'd1) : div_q;
    r_fixed = ((op_q == F_REM) && rs1_q[31]) ? (~div_r + 32'd1) : div_r;
    fix_res = ((op_q == F_REM) || (op_q == F_REMU)) ? r_fixed : q_fixed;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_is_div)     state_d = ST_MUL;
          else if (in_special) state_d = ST_DONE;
          else                 state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (in_flush && (state_q != ST_IDLE))
      state_d = ST_IDLE;
  end

  // Output registers load only on entry to DONE; state_d already excludes flushed ops.
  always_comb begin
    load_out    = (state_d == ST_DONE) && (state_q != ST_DONE);
    next_result = fix_res;
    next_rd     = rd_q;
    case (state_q)
      ST_IDLE: begin
        next_result = special_res;
        next_rd     = in_rd;
      end
      ST_MUL:  next_result = mul_res;
      default: next_result = fix_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= F_MUL;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= funct3_e'(in_funct3);
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        rd_q  <= in_rd;
      end
      if (load_out) begin
        result_q <= next_result;
        rd_out_q <= next_rd;
      end
    end
  end

  assign out_busy   = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_rd     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model predicts result,
// destination, latency and busy window for each issued op; a compare process
// checks every DUT output on every cycle.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        in_flush;
  logic        out_busy;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_flush   (in_flush),
    .out_busy   (out_busy),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state owned by the driver.
  bit          chk_en = 0;
  bit          pend = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          rst_edge_cyc = -1;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_rd = '0;
  bit          use_lit = 0;
  logic [31:0] lit_val = '0;

  // Owned by the compare process.
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 32'd0) return 1;
    if ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_valid;
      bit exp_busy;
      if (cyc == rst_edge_cyc) begin
        last_res = '0;
        last_rd  = '0;
      end
      exp_valid = pend && (cyc == done_cyc);
      exp_busy  = pend && (cyc >= acc_cyc) && (cyc <= done_cyc);
      chk("busy",  {31'b0, out_busy},  {31'b0, exp_busy});
      chk("valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("result", out_result, exp_res);
        chk("rd", {27'b0, out_rd}, {27'b0, exp_rd});
        if (use_lit) chk("literal", out_result, lit_val);
        last_res = exp_res;
        last_rd  = exp_rd;
      end else begin
        chk("result_hold", out_result, last_res);
        chk("rd_hold", {27'b0, out_rd}, {27'b0, last_rd});
      end
    end
  end

  // Called 2 time units after a rising edge; the op is accepted on the next edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit lit_on, input logic [31:0] lit,
                       input bit wait_done);
    in_valid  = 1'b1;
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    exp_res   = golden(f, a, b);
    exp_rd    = rd;
    use_lit   = lit_on;
    lit_val   = lit;
    acc_cyc   = cyc + 1;
    done_cyc  = cyc + latency(f, a, b);
    pend      = 1;
    @(posedge clk); #2;
    in_valid  = 1'b0;
    in_funct3 = 3'($urandom);
    in_rs1    = $urandom;
    in_rs2    = $urandom;
    in_rd     = 5'($urandom);
    if (wait_done) begin
      while (cyc <= done_cyc) begin
        @(posedge clk); #2;
      end
      pend = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1;

    // Directed vectors with hand-computed results.
    issue(OP_MUL,   32'd7,          32'hFFFF_FFFD, 5'd5,  1, 32'hFFFF_FFEB, 1);
    issue(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  1, 32'hFFFF_FFFE, 1);
    issue(OP_DIV,   32'hFFFF_FFEC,  32'd3,         5'd7,  1, 32'hFFFF_FFFA, 1);
    issue(OP_REM,   32'hFFFF_FFEC,  32'd3,         5'd8,  1, 32'hFFFF_FFFE, 1);
    issue(OP_DIVU,  32'd100,        32'd7,         5'd9,  1, 32'd14,        1);
    issue(OP_REMU,  32'd100,        32'd7,         5'd10, 1, 32'd2,         1);
    issue(OP_DIVU,  32'd5,          32'd0,         5'd11, 1, 32'hFFFF_FFFF, 1);
    issue(OP_REM,   32'd5,          32'd0,         5'd12, 1, 32'd5,         1);
    issue(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1, 32'h8000_0000, 1);
    issue(OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1, 32'd0,         1);

    // Flush at divide iteration 10; an in_valid pulse while busy is ignored.
    issue(OP_DIV, 32'd1000, 32'd7, 5'd15, 0, '0, 0);
    repeat (3) begin @(posedge clk); #2; end
    in_valid = 1'b1; in_funct3 = OP_MUL; in_rs1 = 32'd3; in_rs2 = 32'd3; in_rd = 5'd1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #2; end
    in_flush = 1'b1;
    @(posedge clk); #2;
    in_flush = 1'b0;
    pend     = 0;
    issue(OP_MUL, 32'd6, 32'd7, 5'd3, 1, 32'd42, 1);

    // Reset in the middle of a divide.
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd13, 5'd20, 0, '0, 0);
    repeat (5) begin @(posedge clk); #2; end
    reset        = 1'b1;
    rst_edge_cyc = cyc + 1;
    @(posedge clk); #2;
    reset = 1'b0;
    pend  = 0;
    repeat (2) begin @(posedge clk); #2; end

    // in_valid together with in_flush while idle is never accepted.
    in_valid = 1'b1; in_flush = 1'b1; in_funct3 = OP_DIVU; in_rs1 = 32'd9; in_rs2 = 32'd0; in_rd = 5'd4;
    @(posedge clk); #2;
    in_valid = 1'b0; in_flush = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    // Random operands over all funct3 values, issued back to back.
    for (int i = 0; i < 32; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'(i % 8);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(1, 20);
      if (i % 4 == 2) a = -$urandom_range(1, 1000);
      if (i % 11 == 5) b = 32'd0;
      issue(f, a, b, 5'(i), 0, '0, 1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
